// File: rtl/apb2axi_bridge.sv
// apb2axi_bridge: APB slave to AXI4 master; each APB access becomes one single-beat 32-bit AXI transfer.
// Define APB2AXI_POSTED_WR_EN to post writes (pready once AW/W complete; the B response is drained in the background).
module apb2axi_bridge #(
    parameter int                          AXI_ID_WIDTH   = 6,
    parameter int                          AXI_ADDR_WIDTH = 32,
    parameter int                          AXI_DATA_WIDTH = 64,
    parameter int                          APB_ADDR_WIDTH = 32,
    parameter logic [AXI_ID_WIDTH-1:0]     AXI_ID         = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0]   AXI_ADDR_BASE  = '0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [APB_ADDR_WIDTH-1:0]     paddr,
    input  logic [31:0]                   pwdata,
    output logic [31:0]                   prdata,
    output logic                          pready,
    output logic                          pslverr,
    output logic [AXI_ID_WIDTH-1:0]       AWID,
    output logic [AXI_ADDR_WIDTH-1:0]     AWADDR,
    output logic [7:0]                    AWLEN,
    output logic [2:0]                    AWSIZE,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]     WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   WSTRB,
    output logic                          WLAST,
    output logic                          WVALID,
    input  logic                          WREADY,
    input  logic [AXI_ID_WIDTH-1:0]       BID,
    input  logic [1:0]                    BRESP,
    input  logic                          BVALID,
    output logic                          BREADY,
    output logic [AXI_ID_WIDTH-1:0]       ARID,
    output logic [AXI_ADDR_WIDTH-1:0]     ARADDR,
    output logic [7:0]                    ARLEN,
    output logic [2:0]                    ARSIZE,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]       RID,
    input  logic [AXI_DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RLAST,
    input  logic                          RVALID,
    output logic                          RREADY
);
    localparam int NLANES = AXI_DATA_WIDTH / 32;
    localparam int LW     = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_D, S_DONE} state_t;

    state_t                      r_state;
    logic [AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]                 r_wdata;
    logic [31:0]                 r_prdata;
    logic [LW-1:0]               r_lane;
    logic                        r_awvalid, r_wvalid, r_arvalid, r_rready;
    logic                        r_aw_done, r_w_done, r_pready, r_pslverr;
    logic [LW-1:0]               w_lane;
    logic [NLANES-1:0][31:0]     w_rlanes;
    logic [STRB_W-1:0]           w_strb_base;
    logic [AXI_ADDR_WIDTH-1:0]   w_addr;
    logic                        w_aw_fin, w_w_fin, w_b_busy;
    logic                        w_unused;

    generate
        if (NLANES > 1) begin : g_lane
            assign w_lane = paddr[LW+1:2];
        end else begin : g_lane1
            assign w_lane = '0;
        end
    endgenerate

    assign w_addr      = AXI_ADDR_BASE | AXI_ADDR_WIDTH'({paddr[APB_ADDR_WIDTH-1:2], 2'b00});
    assign w_rlanes    = RDATA;
    assign w_strb_base = STRB_W'(4'hF);
    assign w_aw_fin    = r_aw_done | (r_awvalid & AWREADY);
    assign w_w_fin     = r_w_done  | (r_wvalid  & WREADY);
    // Single-outstanding design: IDs and RLAST carry no information here.
    assign w_unused    = ^{BID, RID, RLAST, BRESP, RRESP[0], paddr[1:0]};

    assign AWID    = AXI_ID;
    assign ARID    = AXI_ID;
    assign AWADDR  = r_addr;
    assign ARADDR  = r_addr;
    assign AWLEN   = 8'd0;
    assign ARLEN   = 8'd0;
    assign AWSIZE  = 3'b010;
    assign ARSIZE  = 3'b010;
    assign WLAST   = 1'b1;
    assign WDATA   = {NLANES{r_wdata}};
    assign WSTRB   = w_strb_base << {r_lane, 2'b00};
    assign AWVALID = r_awvalid;
    assign WVALID  = r_wvalid;
    assign ARVALID = r_arvalid;
    assign RREADY  = r_rready;
    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

`ifdef APB2AXI_POSTED_WR_EN
    logic r_pend_b;
    assign BREADY   = r_pend_b;
    // A B handshake in this very cycle frees IDLE to launch immediately.
    assign w_b_busy = r_pend_b & ~BVALID;
`else
    logic r_bready;
    assign BREADY   = r_bready;
    assign w_b_busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_lane    <= '0;
            r_prdata  <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
`ifdef APB2AXI_POSTED_WR_EN
            r_pend_b  <= 1'b0;
`else
            r_bready  <= 1'b0;
`endif
        end else begin
            r_pready <= 1'b0;
`ifdef APB2AXI_POSTED_WR_EN
            if (r_pend_b && BVALID) r_pend_b <= 1'b0;
`endif
            case (r_state)
                S_IDLE: if (psel && penable && !w_b_busy) begin
                    r_addr  <= w_addr;
                    r_lane  <= w_lane;
                    r_wdata <= pwdata;
                    if (pwrite) begin
                        r_state   <= S_WR;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        r_state   <= S_RD_A;
                        r_arvalid <= 1'b1;
                    end
                end
                S_WR: begin
                    if (r_awvalid && AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && WREADY) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
`ifdef APB2AXI_POSTED_WR_EN
                        r_state   <= S_DONE;
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b0;
                        r_pend_b  <= 1'b1;
`else
                        r_state  <= S_WR_B;
                        r_bready <= 1'b1;
`endif
                    end
                end
`ifndef APB2AXI_POSTED_WR_EN
                S_WR_B: if (BVALID) begin
                    r_bready  <= 1'b0;
                    r_pslverr <= BRESP[1];
                    r_pready  <= 1'b1;
                    r_state   <= S_DONE;
                end
`endif
                S_RD_A: if (ARREADY) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= S_RD_D;
                end
                S_RD_D: if (RVALID) begin
                    r_rready  <= 1'b0;
                    r_prdata  <= w_rlanes[r_lane];
                    r_pslverr <= RRESP[1];
                    r_pready  <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb2axi_bridge.sv
// Self-checking bench for apb2axi_bridge (default 64-bit AXI data, AXI_ID=0, AXI_ADDR_BASE=0).
// The bench acts as APB master and AXI slave with per-transfer READY/VALID delays.
module tb_apb2axi_bridge;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0, prdata;
    logic        pready, pslverr;
    logic [5:0]  AWID, ARID, BID = '0, RID = '0;
    logic [31:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN, WSTRB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [63:0] WDATA, RDATA = '0;
    logic [1:0]  BRESP = '0, RRESP = '0;
    logic        AWVALID, AWREADY = 1'b0, WLAST, WVALID, WREADY = 1'b0;
    logic        BVALID = 1'b0, BREADY, ARVALID, ARREADY = 1'b0;
    logic        RLAST = 1'b0, RVALID = 1'b0, RREADY;

    always #5 clk = ~clk;

    apb2axi_bridge dut (
        .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    int vectors = 0, miscompares = 0, cyc = 0;
    int aw_dly, w_dly, ar_dly, r_dly, b_dly = 0;
    int awc, wc, arc, rc, bc = 0;
    bit aw_hs, w_hs, ar_hs, r_hs, b_hs, aw_pend, w_pend, ar_pend, b_pend;
    int b_hs_cyc = -1, ar_first_cyc = -1, viol = 0;
    logic        t_wr, c_err, c_post_pready, c_bready_pre;
    logic [63:0] t_rdata, c_wdata;
    logic [1:0]  t_rresp, t_bresp = 2'b00;
    logic [31:0] c_addr, c_prdata;
    logic [7:0]  c_wstrb;
    logic [17:0] c_ctl;
    localparam logic [17:0] CTL_EXP = {8'd0, 3'b010, 6'd0, 1'b1};

    // ---------------- reference model (address/lane/latency rules) ----------------
    function automatic logic [31:0] m_addr(input logic [31:0] a);
        return a - (a % 4);
    endfunction
    function automatic logic [7:0] m_strb(input logic [31:0] a);
        return ((a % 8) < 4) ? 8'h0F : 8'hF0;
    endfunction
    function automatic logic [31:0] m_rd(input logic [31:0] a, input logic [63:0] d);
        return ((a % 8) < 4) ? d[31:0] : d[63:32];
    endfunction
    function automatic int m_wlat(input int awd, input int wdd, input int bd);
        int m = (awd > wdd) ? awd : wdd;
`ifdef APB2AXI_POSTED_WR_EN
        return 3 + m;
`else
        return 4 + m + bd;
`endif
    endfunction
    function automatic logic m_werr(input logic [1:0] r);
`ifdef APB2AXI_POSTED_WR_EN
        return 1'b0;
`else
        return r >= 2'd2;
`endif
    endfunction

    // ---------------- AXI slave / APB master drivers ----------------
    task automatic edge_drive();
        @(posedge clk); #1; cyc++;
        AWREADY = AWVALID && (awc >= aw_dly);
        WREADY  = WVALID && (wc >= w_dly);
        ARREADY = ARVALID && (arc >= ar_dly);
        BVALID  = BREADY && (bc >= b_dly);
        BRESP   = BVALID ? t_bresp : 2'b00;
        RVALID  = RREADY && (rc >= r_dly);
        RDATA   = RVALID ? t_rdata : {$urandom, $urandom};
        RRESP   = RVALID ? t_rresp : 2'b00;
        RLAST   = RVALID;
    endtask

    // Records handshakes and counts protocol violations (retracted VALID, VALID after
    // handshake, dropped BREADY, pready before the response).
    task automatic sample();
        bit resp_seen;
        @(negedge clk);
        if (AWVALID) begin
            if (aw_hs) viol++;
            if (AWREADY) begin aw_hs = 1; c_addr = AWADDR; c_ctl[17:1] = {AWLEN, AWSIZE, AWID}; end
            else awc++;
        end else if (aw_pend) viol++;
        aw_pend = AWVALID && !AWREADY;
        if (WVALID) begin
            if (w_hs) viol++;
            if (WREADY) begin w_hs = 1; c_wdata = WDATA; c_wstrb = WSTRB; c_ctl[0] = WLAST; end
            else wc++;
        end else if (w_pend) viol++;
        w_pend = WVALID && !WREADY;
        if (ARVALID) begin
            if (ar_first_cyc < 0) ar_first_cyc = cyc;
            if (ar_hs) viol++;
            if (ARREADY) begin ar_hs = 1; c_addr = ARADDR; c_ctl = {ARLEN, ARSIZE, ARID, 1'b1}; end
            else arc++;
        end else if (ar_pend) viol++;
        ar_pend = ARVALID && !ARREADY;
        if (!BREADY && b_pend) viol++;
        if (BREADY && BVALID) begin b_hs = 1; b_hs_cyc = cyc; bc = 0; end
        else if (BREADY) bc++;
        b_pend = BREADY && !BVALID;
        if (RREADY && RVALID) r_hs = 1;
        else if (RREADY) rc++;
`ifdef APB2AXI_POSTED_WR_EN
        resp_seen = t_wr ? (aw_hs && w_hs) : r_hs;
`else
        resp_seen = t_wr ? b_hs : r_hs;
`endif
        if (pready && !resp_seen) viol++;
    endtask

    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [63:0] rd, input logic [1:0] resp,
                        input int awd, input int wdd, input int ard, input int rdd, input int bd,
                        input int abort_at, output int lat);
        t_wr = wr; aw_dly = awd; w_dly = wdd; ar_dly = ard; r_dly = rdd;
        awc = 0; wc = 0; arc = 0; rc = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; r_hs = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
        viol = 0; ar_first_cyc = -1;
        t_rdata = rd;
        if (wr) begin t_bresp = resp; b_dly = bd; bc = 0; b_hs = 0; b_pend = 0; end
        else t_rresp = resp;
        c_addr = '0; c_wdata = '0; c_wstrb = '0; c_ctl = '0; c_prdata = '0; c_err = 1'b0;
        lat = 0;
        edge_drive();
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        sample();
        for (int c = 1; c <= 200; c++) begin
            edge_drive();
            if (c == 1) penable = 1'b1;
            sample();
            if (c == abort_at) begin
                c_bready_pre = BREADY;
                rstn = 1'b0;
                #1;
                return;
            end
            if (pready) begin lat = c; c_prdata = prdata; c_err = pslverr; break; end
        end
        if (lat == 0) begin
            vectors++; miscompares++;
            $display("FAIL xfer_timeout: pready=0 after 200 cycles, want pready=1");
        end
        edge_drive();
        psel = 1'b0; penable = 1'b0;
        sample();
        c_post_pready = pready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, pready, pslverr} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 0000000", {AWVALID, WVALID, ARVALID, BREADY, RREADY, pready, pslverr});
        end
        vectors++;
        if (prdata !== 32'h0) begin miscompares++; $display("FAIL reset_prdata: got %h want 0", prdata); end
        vectors++;
        if ({AWLEN, AWSIZE, AWID, WLAST} !== CTL_EXP || {ARLEN, ARSIZE, ARID} !== CTL_EXP[17:1]) begin
            miscompares++;
            $display("FAIL reset_const: got %h/%h want %h", {AWLEN, AWSIZE, AWID, WLAST}, {ARLEN, ARSIZE, ARID}, CTL_EXP);
        end
        @(posedge clk); #1; rstn = 1'b1;
    endtask

    task automatic test_write_basic();
        int lat;
        xfer(1'b1, 32'h104, 32'hA5A5_1234, 64'h0, 2'b00, 0, 0, 0, 0, 0, 0, lat);
        vectors++;
        if (lat !== m_wlat(0, 0, 0)) begin miscompares++; $display("FAIL wr_lat: got %0d want %0d", lat, m_wlat(0, 0, 0)); end
        vectors++;
        if (c_addr !== 32'h104) begin miscompares++; $display("FAIL wr_awaddr: got %h want 104", c_addr); end
        vectors++;
        if (c_wstrb !== 8'hF0) begin miscompares++; $display("FAIL wr_wstrb: got %h want f0", c_wstrb); end
        vectors++;
        if (c_wdata !== 64'hA5A51234_A5A51234) begin miscompares++; $display("FAIL wr_wdata: got %h want a5a51234a5a51234", c_wdata); end
        vectors++;
        if (c_ctl !== CTL_EXP) begin miscompares++; $display("FAIL wr_ctl: got %h want %h", c_ctl, CTL_EXP); end
        vectors++;
        if (c_err !== 1'b0 || viol != 0 || c_post_pready !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_status: got err=%b viol=%0d pready_after=%b want 0/0/0", c_err, viol, c_post_pready);
        end
    endtask

    task automatic test_read_lanes();
        int lat;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? 32'h200 : 32'h204;
            xfer(1'b0, a, 32'h0, 64'h1111_2222_3333_4444, 2'b00, 0, 0, 0, 0, 0, 0, lat);
            vectors++;
            if (c_prdata !== m_rd(a, 64'h1111_2222_3333_4444) || c_addr !== a || lat != 4) begin
                miscompares++;
                $display("FAIL rd_lane%0d: got prdata=%h araddr=%h lat=%0d want %h/%h/4",
                         i, c_prdata, c_addr, lat, m_rd(a, 64'h1111_2222_3333_4444), a);
            end
            vectors++;
            if (c_err !== 1'b0 || viol != 0 || c_ctl !== CTL_EXP) begin
                miscompares++;
                $display("FAIL rd_status%0d: got err=%b viol=%0d ctl=%h want 0/0/%h", i, c_err, viol, c_ctl, CTL_EXP);
            end
        end
        edge_drive(); sample(); edge_drive(); sample();
        vectors++;
        if (prdata !== 32'h1111_2222) begin miscompares++; $display("FAIL rd_hold: got %h want 11112222", prdata); end
    endtask

    task automatic test_write_delayed();
        int lat;
        xfer(1'b1, 32'h38, 32'hDEAD_BEEF, 64'h0, 2'b00, 3, 0, 0, 0, 5, 0, lat);
        vectors++;
        if (lat != m_wlat(3, 0, 5)) begin miscompares++; $display("FAIL wr_dly_lat: got %0d want %0d", lat, m_wlat(3, 0, 5)); end
        vectors++;
        if (viol != 0) begin miscompares++; $display("FAIL wr_dly_proto: got %0d violations want 0", viol); end
        vectors++;
        if (c_wstrb !== 8'h0F || c_wdata !== 64'hDEADBEEF_DEADBEEF || c_addr !== 32'h38) begin
            miscompares++;
            $display("FAIL wr_dly_data: got %h/%h/%h want 0f/deadbeefdeadbeef/38", c_wstrb, c_wdata, c_addr);
        end
    endtask

    task automatic test_errors();
        int lat;
        xfer(1'b0, 32'h84, 32'h0, 64'hCAFE_0001_0BAD_F00D, 2'b11, 0, 0, 1, 0, 0, 0, lat);
        vectors++;
        if (c_err !== 1'b1 || c_prdata !== 32'hCAFE_0001) begin
            miscompares++; $display("FAIL rd_decerr: got err=%b prdata=%h want 1/cafe0001", c_err, c_prdata);
        end
        xfer(1'b0, 32'h80, 32'h0, 64'hCAFE_0001_0BAD_F00D, 2'b00, 0, 0, 0, 0, 0, 0, lat);
        vectors++;
        if (c_err !== 1'b0 || c_prdata !== 32'h0BAD_F00D) begin
            miscompares++; $display("FAIL rd_okay: got err=%b prdata=%h want 0/0badf00d", c_err, c_prdata);
        end
        xfer(1'b1, 32'h8, 32'h1234_5678, 64'h0, 2'b10, 0, 1, 0, 0, 0, 0, lat);
        vectors++;
        if (c_err !== m_werr(2'b10) || lat != m_wlat(0, 1, 0)) begin
            miscompares++; $display("FAIL wr_slverr: got err=%b lat=%0d want %b/%0d", c_err, lat, m_werr(2'b10), m_wlat(0, 1, 0));
        end
    endtask

`ifndef APB2AXI_POSTED_WR_EN
    task automatic test_reset_mid();
        int lat;
        xfer(1'b1, 32'h10, 32'h5555_AAAA, 64'h0, 2'b00, 0, 0, 0, 0, 30, 4, lat);
        vectors++;
        if (c_bready_pre !== 1'b1) begin miscompares++; $display("FAIL rst_mid_wrb: got bready=%b want 1", c_bready_pre); end
        vectors++;
        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, pready} !== 6'b0) begin
            miscompares++;
            $display("FAIL rst_mid_outs: got %b want 000000", {AWVALID, WVALID, ARVALID, BREADY, RREADY, pready});
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; BVALID = 1'b0; b_pend = 0; rstn = 1'b1;
        xfer(1'b0, 32'hC, 32'h0, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0, 1, 1, 0, 0, lat);
        vectors++;
        if (lat != 6 || c_prdata !== 32'h0123_4567 || c_err !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_read: got lat=%0d prdata=%h err=%b want 6/01234567/0", lat, c_prdata, c_err);
        end
    endtask
`endif

    task automatic test_random();
        int lat, awd, wdd, ard, rdd, bd, exp_lat;
        bit wr;
        logic [31:0] a, wd;
        logic [63:0] rd;
        logic [1:0] resp;
        for (int i = 0; i < 24; i++) begin
            wr = $urandom_range(0, 1) != 0;
            a = $urandom & 32'h0000_FFFF; wd = $urandom; rd = {$urandom, $urandom};
            resp = 2'($urandom_range(0, 3));
            awd = $urandom_range(0, 3); wdd = $urandom_range(0, 3);
            ard = $urandom_range(0, 3); rdd = $urandom_range(0, 3);
`ifdef APB2AXI_POSTED_WR_EN
            bd = 0;
`else
            bd = $urandom_range(0, 3);
`endif
            xfer(wr, a, wd, rd, resp, awd, wdd, ard, rdd, bd, 0, lat);
            exp_lat = wr ? m_wlat(awd, wdd, bd) : 4 + ard + rdd;
            vectors++;
            if (lat != exp_lat || viol != 0 || c_addr !== m_addr(a) || c_ctl !== CTL_EXP) begin
                miscompares++;
                $display("FAIL rnd%0d_addr: got lat=%0d viol=%0d addr=%h ctl=%h want %0d/0/%h/%h",
                         i, lat, viol, c_addr, c_ctl, exp_lat, m_addr(a), CTL_EXP);
            end
            vectors++;
            if (wr) begin
                if (c_wdata !== {wd, wd} || c_wstrb !== m_strb(a) || c_err !== m_werr(resp)) begin
                    miscompares++;
                    $display("FAIL rnd%0d_wr: got %h/%h/%b want %h/%h/%b", i, c_wdata, c_wstrb, c_err, {wd, wd}, m_strb(a), m_werr(resp));
                end
            end else if (c_prdata !== m_rd(a, rd) || c_err !== (resp >= 2'd2)) begin
                miscompares++;
                $display("FAIL rnd%0d_rd: got %h/%b want %h/%b", i, c_prdata, c_err, m_rd(a, rd), resp >= 2'd2);
            end
        end
    endtask

`ifdef APB2AXI_POSTED_WR_EN
    task automatic test_posted();
        int lat;
        xfer(1'b1, 32'h40, 32'h7777_0000, 64'h0, 2'b10, 0, 0, 0, 0, 10, 0, lat);
        vectors++;
        if (lat != 3 || c_err !== 1'b0 || b_hs) begin
            miscompares++; $display("FAIL posted_wr: got lat=%0d err=%b b_done=%0d want 3/0/0", lat, c_err, b_hs);
        end
        xfer(1'b0, 32'h44, 32'h0, 64'h9999_8888_0000_0000, 2'b00, 0, 0, 0, 0, 0, 0, lat);
        vectors++;
        if (!b_hs || ar_first_cyc != b_hs_cyc + 1 || c_prdata !== 32'h9999_8888) begin
            miscompares++;
            $display("FAIL posted_b2b: got ar_cyc=%0d b_cyc=%0d prdata=%h want b_cyc+1/99998888",
                     ar_first_cyc, b_hs_cyc, c_prdata);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_lanes();
        test_write_delayed();
        test_errors();
`ifndef APB2AXI_POSTED_WR_EN
        test_reset_mid();
`else
        test_posted();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
